// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked sub-word data memory:
// access-size encodings, FSM state encoding, lane-enable and load-extension helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_ILL  = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Bit i of the result enables byte lane i (lane 0 = bits [31:24], big-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo;
            SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Extends right-justified load data to 32 bits; unsigned is ignored for words.
    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                           input logic [31:0] raw);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{~uns & raw[7]}}, raw[7:0]};
            SZ_HALF: r = {{16{~uns & raw[15]}}, raw[15:0]};
            SZ_WORD: r = raw;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Even parity bit for one byte: the 9-bit {parity, byte} has an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// One byte lane of the data memory: synchronous write, READ_LAT-stage registered read.
// The first read stage only loads on a read so a finished read stays stable at the output.
module dmem_byte_lane #(
    parameter int AW       = 8,
    parameter int W        = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_r  [2**AW];
    logic [W-1:0] pipe_r [READ_LAT];

    // Lane storage write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[addr_i] <= wdata_i;
        end
    end

    // Read pipeline: capture on read, then shift toward the output every cycle.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            pipe_r[0] <= mem_r[addr_i];
        end
        for (int k = 1; k < READ_LAT; k++) begin
            pipe_r[k] <= pipe_r[k-1];
        end
    end

    assign rdata_o = pipe_r[READ_LAT-1];

endmodule

// File: rtl/dmem_hs_subword.sv
// Handshaked, byte-addressable big-endian data memory with byte/half/word access,
// configurable read latency, and sticky misalignment/overflow error flags.
// Optional per-byte parity is enabled by defining DMEM_BYTE_PARITY_EN.
module dmem_hs_subword
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef DMEM_BYTE_PARITY_EN
    input  logic        inj_parity_i,
    output logic        err_parity_o,
`endif
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        err_misalign_o,
    output logic        err_overflow_o,
    input  logic        err_clr_i
);

    localparam int WI_W = ADDR_W - 2;
`ifdef DMEM_BYTE_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam logic [1:0] WAIT_INIT = 2'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic        rsp_err_r;
    logic        resp_load_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [1:0]  lo_r;

    logic        accept_s;
    logic        ovf_s;
    logic        mis_s;
    logic        legal_s;
    logic        wr_s;
    logic        rd_s;
    logic [3:0]  mask_s;
    logic [31:0] wword_s;
    logic [31:0] raw_word_s;
    logic [31:0] sel_s;
    logic [LANE_W-1:0] lane_wdata_s [4];
    logic [LANE_W-1:0] lane_rdata_s [4];

    assign accept_s = req_valid_i & req_ready_o;
    assign ovf_s    = (req_size_i == SZ_ILL) | (|req_addr_i[31:ADDR_W]);
    assign mis_s    = ~ovf_s & (((req_size_i == SZ_HALF) & req_addr_i[0]) |
                                ((req_size_i == SZ_WORD) & (req_addr_i[1:0] != 2'b00)));
    assign legal_s  = ~ovf_s & ~mis_s;
    assign wr_s     = accept_s & legal_s & req_we_i;
    assign rd_s     = accept_s & legal_s & ~req_we_i;
    assign mask_s   = lane_mask(req_size_i, req_addr_i[1:0]);

    // Place right-justified store data onto the big-endian lanes it targets.
    always_comb begin
        wword_s = 32'h0000_0000;
        case (req_size_i)
            SZ_BYTE: wword_s = {24'h00_0000, req_wdata_i[7:0]} << {~req_addr_i[1:0], 3'b000};
            SZ_HALF: wword_s = {16'h0000, req_wdata_i[15:0]} << {~req_addr_i[1], 4'b0000};
            SZ_WORD: wword_s = req_wdata_i;
            default: wword_s = 32'h0000_0000;
        endcase
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_lane
`ifdef DMEM_BYTE_PARITY_EN
            assign lane_wdata_s[g] = {byte_parity(wword_s[8*(3-g) +: 8]) ^ inj_parity_i,
                                      wword_s[8*(3-g) +: 8]};
`else
            assign lane_wdata_s[g] = wword_s[8*(3-g) +: 8];
`endif
            dmem_byte_lane #(
                .AW       (WI_W),
                .W        (LANE_W),
                .READ_LAT (READ_LAT)
            ) u_lane (
                .clk_i   (clk_i),
                .we_i    (wr_s & mask_s[g]),
                .re_i    (rd_s),
                .addr_i  (req_addr_i[ADDR_W-1:2]),
                .wdata_i (lane_wdata_s[g]),
                .rdata_o (lane_rdata_s[g])
            );
        end
    endgenerate

    assign raw_word_s = {lane_rdata_s[0][7:0], lane_rdata_s[1][7:0],
                         lane_rdata_s[2][7:0], lane_rdata_s[3][7:0]};

    // Right-justify the accessed bytes of the read word for extension.
    always_comb begin
        sel_s = 32'h0000_0000;
        case (size_r)
            SZ_BYTE: sel_s = raw_word_s >> {~lo_r, 3'b000};
            SZ_HALF: sel_s = raw_word_s >> {~lo_r[1], 4'b0000};
            SZ_WORD: sel_s = raw_word_s;
            default: sel_s = 32'h0000_0000;
        endcase
    end

    assign rsp_rdata_o = resp_load_r ? extend(size_r, uns_r, sel_s) : 32'h0000_0000;

    // Request/response sequencing: accept, optional latency wait, hold response until taken.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_r   <= 1'b0;
            resp_load_r <= 1'b0;
            size_r      <= SZ_ILL;
            uns_r       <= 1'b0;
            lo_r        <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        size_r      <= req_size_i;
                        uns_r       <= req_unsigned_i;
                        lo_r        <= req_addr_i[1:0];
                        req_ready_o <= 1'b0;
                        if (!legal_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            resp_load_r <= 1'b0;
                        end else if (req_we_i) begin
                            state_r     <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            resp_load_r <= 1'b0;
                        end else if (READ_LAT == 1) begin
                            state_r     <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            resp_load_r <= 1'b1;
                        end else begin
                            state_r     <= ST_WAIT;
                            cnt_r       <= WAIT_INIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 2'd0) begin
                        state_r     <= ST_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        resp_load_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r     <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        resp_load_r <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    resp_load_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags: set by an erroneous accept, cleared by err_clr_i; set wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_overflow_o <= 1'b0;
            err_misalign_o <= 1'b0;
        end else begin
            err_overflow_o <= (accept_s & ovf_s) | (err_overflow_o & ~err_clr_i);
            err_misalign_o <= (accept_s & mis_s) | (err_misalign_o & ~err_clr_i);
        end
    end

`ifdef DMEM_BYTE_PARITY_EN
    logic [3:0] mask_r;
    logic [3:0] lane_bad_s;
    logic       par_err_s;

    for (genvar p = 0; p < 4; p++) begin : g_pchk
        assign lane_bad_s[p] = ^lane_rdata_s[p];
    end
    assign par_err_s = resp_load_r & (|(mask_r & lane_bad_s));
    assign rsp_err_o = rsp_err_r | par_err_s;

    // Remember which lanes the accepted request touches, for the parity check.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mask_r <= 4'b0000;
        end else if (accept_s) begin
            mask_r <= mask_s;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Sticky parity flag: set while a load response shows a bad lane; set wins over clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_parity_o <= 1'b0;
        end else begin
            err_parity_o <= ((state_r == ST_RESP) & par_err_s) | (err_parity_o & ~err_clr_i);
        end
    end
`else
    assign rsp_err_o = rsp_err_r;
`endif

endmodule
